// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between an instruction-fetch port and a load/store port.
// One transaction in flight at a time; all memory strobes and ready pulses are registered.
module mem_arbiter #(
  parameter int          RD_LAT    = 1,
  parameter bit          FIXED_PRI = 1'b0,
  parameter logic [15:0] PROT_TOP  = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ready,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ready,
  output logic [15:0] d_rdata,
  output logic        d_err,
  output logic        r_en,
  output logic        w_en,
  output logic [15:0] addr,
  output logic [15:0] w_data,
  input  logic [15:0] r_data,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshake: a port raises req and holds its command until the one-cycle ready pulse;
  // in that ready cycle it must drop req or present the next command.

  typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

  localparam logic       OWN_FETCH = 1'b0;
  localparam logic       OWN_DATA  = 1'b1;
  localparam logic [2:0] CNT_INIT  = 3'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic        blocked_q, blocked_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        r_en_q, r_en_d;
  logic        w_en_q, w_en_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] w_data_q, w_data_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;
  logic        d_err_q, d_err_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        grant;
  logic [16:0] prot_diff;
  logic        below_prot;

  // Borrow out of d_addr - PROT_TOP means d_addr < PROT_TOP; PROT_TOP=0 never borrows.
  assign prot_diff  = {1'b0, d_addr} - {1'b0, PROT_TOP};
  assign below_prot = prot_diff[16];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    blocked_d    = blocked_q;
    cnt_d        = cnt_q;
    r_en_d       = 1'b0;
    w_en_d       = 1'b0;
    addr_d       = addr_q;
    w_data_d     = w_data_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;
    d_err_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant        = OWN_FETCH;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          if (if_req && d_req) grant = FIXED_PRI ? OWN_DATA : ~last_grant_q;
          else                 grant = d_req ? OWN_DATA : OWN_FETCH;
          owner_d      = grant;
          last_grant_d = grant;
          we_d         = grant & d_we;
          addr_d       = grant ? d_addr : if_addr;
          if (grant) w_data_d = d_wdata;
          if (grant && d_we && below_prot) begin
            blocked_d = 1'b1;
            state_d   = DONE;
          end else begin
            blocked_d = 1'b0;
            r_en_d    = ~(grant & d_we);
            w_en_d    = grant & d_we;
            state_d   = CMD;
          end
        end
      end
      CMD: begin
        if (we_q) begin
          state_d = DONE;
        end else if (RD_LAT <= 1) begin
          if (owner_q) d_rdata_d = r_data;
          else         if_rdata_d = r_data;
          state_d = DONE;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // cnt holds the WAIT cycles still to go; the last one captures the read data.
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (owner_q) d_rdata_d = r_data;
          else         if_rdata_d = r_data;
          state_d = DONE;
        end
      end
      DONE: begin
        if_ready_d = ~owner_q;
        d_ready_d  = owner_q;
        d_err_d    = owner_q & blocked_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_FETCH;
      last_grant_q <= OWN_FETCH;
      we_q         <= 1'b0;
      blocked_q    <= 1'b0;
      cnt_q        <= 3'd0;
      r_en_q       <= 1'b0;
      w_en_q       <= 1'b0;
      addr_q       <= 16'h0000;
      w_data_q     <= 16'h0000;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      d_err_q      <= 1'b0;
      if_rdata_q   <= 16'h0000;
      d_rdata_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      blocked_q    <= blocked_d;
      cnt_q        <= cnt_d;
      r_en_q       <= r_en_d;
      w_en_q       <= w_en_d;
      addr_q       <= addr_d;
      w_data_q     <= w_data_d;
      if_ready_q   <= if_ready_d;
      d_ready_q    <= d_ready_d;
      d_err_q      <= d_err_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign r_en      = r_en_q;
  assign w_en      = w_en_q;
  assign addr      = addr_q;
  assign w_data    = w_data_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign d_err     = d_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (round-robin/RD_LAT=1/protected, fixed-priority/RD_LAT=3)
// with behavioural memories, a queue scoreboard per port and a ready-driven monitor.
module tb_mem_arbiter;

  localparam int W = 50;  // {check_data, exp_cycle[31:0], exp_err, exp_data[15:0]}

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [1:0]       if_req, d_req, d_we;
  logic [1:0][15:0] if_addr, d_addr, d_wdata;
  wire  [1:0]       if_ready, d_ready, d_err, r_en, w_en, busy;
  wire  [1:0][15:0] if_rdata, d_rdata, addr, w_data, r_data;
  wire  [1:0][1:0]  state_dbg;

  logic [15:0] mem [2][65536];
  logic [15:0] rd_p0, rd_p1;

  logic [W-1:0] exp_q[4][$];
  int           n_ren[2];
  int           n_wen[2];
  logic [15:0]  last_saddr[2];
  logic [1:0]   ren_prev = 2'b00;
  logic [1:0]   wen_prev = 2'b00;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  mem_arbiter #(.RD_LAT(1), .FIXED_PRI(1'b0), .PROT_TOP(16'h1000)) u_rr (
    .clk(clk), .reset(reset),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ready(if_ready[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_ready(d_ready[0]), .d_rdata(d_rdata[0]), .d_err(d_err[0]),
    .r_en(r_en[0]), .w_en(w_en[0]), .addr(addr[0]), .w_data(w_data[0]), .r_data(r_data[0]),
    .busy(busy[0]), .state_dbg(state_dbg[0])
  );

  mem_arbiter #(.RD_LAT(3), .FIXED_PRI(1'b1), .PROT_TOP(16'h0000)) u_fx (
    .clk(clk), .reset(reset),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ready(if_ready[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_ready(d_ready[1]), .d_rdata(d_rdata[1]), .d_err(d_err[1]),
    .r_en(r_en[1]), .w_en(w_en[1]), .addr(addr[1]), .w_data(w_data[1]), .r_data(r_data[1]),
    .busy(busy[1]), .state_dbg(state_dbg[1])
  );

  // Memory models: instance 0 reads combinationally, instance 1 has two output stages.
  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 65536; a++) mem[i][a] = 16'(a) ^ 16'h5A5A;
    mem[0][0] = 16'hABCD;
    mem[1][0] = 16'hABCD;
    rd_p0 = 16'h0000;
    rd_p1 = 16'h0000;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) if (w_en[i]) mem[i][addr[i]] <= w_data[i];
      if (r_en[1]) rd_p0 <= mem[1][addr[1]];
      rd_p1 <= rd_p0;
    end
  end
  assign r_data[0] = mem[0][addr[0]];
  assign r_data[1] = rd_p1;

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        logic         rdy;
        logic [15:0]  rd;
        logic [W-1:0] e;
        rdy = (p == 0) ? if_ready[i] : d_ready[i];
        rd  = (p == 0) ? if_rdata[i] : d_rdata[i];
        if (rdy) begin
          chk($sformatf("u%0d p%0d ready_expected", i, p), 32'(exp_q[2*i+p].size() != 0), 32'd1);
          if (exp_q[2*i+p].size() != 0) begin
            e = exp_q[2*i+p].pop_front();
            if (e[49]) chk($sformatf("u%0d p%0d rdata", i, p), 32'(rd), 32'(e[15:0]));
            chk($sformatf("u%0d p%0d d_err", i, p), 32'(d_err[i]), 32'(e[16]));
            if (e[48:17] != 32'd0) chk($sformatf("u%0d p%0d latency", i, p), 32'(cyc), e[48:17]);
          end
        end
      end
      if (if_ready[i] || d_ready[i])
        chk($sformatf("u%0d ready_exclusive", i), 32'(if_ready[i] & d_ready[i]), 32'd0);
      if (d_err[i]) chk($sformatf("u%0d d_err_with_ready", i), 32'(d_ready[i]), 32'd1);
      if (r_en[i] || w_en[i]) begin
        chk($sformatf("u%0d strobe_single", i),
            32'({r_en[i] & ren_prev[i], w_en[i] & wen_prev[i], r_en[i] & w_en[i]}), 32'd0);
        last_saddr[i] = addr[i];
      end
      if (r_en[i]) n_ren[i]++;
      if (w_en[i]) n_wen[i]++;
      ren_prev[i] = r_en[i];
      wen_prev[i] = w_en[i];
    end
  end

  // ---------------- drivers ----------------
  // Called at a negedge; with hold=1 the request stays up so the next call replaces it in the ready cycle.
  task automatic fetch_tx(input int i, input logic [15:0] a, input logic [15:0] exp_data,
                          input int exp_cyc, input bit hold);
    bit got = 1'b0;
    if_req[i]  = 1'b1;
    if_addr[i] = a;
    exp_q[2*i].push_back({1'b1, 32'(exp_cyc), 1'b0, exp_data});
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = if_ready[i];
    end
    if (!hold) if_req[i] = 1'b0;
    chk($sformatf("u%0d fetch_completes", i), 32'(got), 32'd1);
  endtask

  task automatic data_tx(input int i, input bit we, input logic [15:0] a, input logic [15:0] wd,
                         input logic [15:0] exp_data, input bit exp_err, input int exp_cyc,
                         input bit hold);
    bit got = 1'b0;
    d_req[i]   = 1'b1;
    d_we[i]    = we;
    d_addr[i]  = a;
    d_wdata[i] = wd;
    exp_q[2*i+1].push_back({~we, 32'(exp_cyc), exp_err, exp_data});
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = d_ready[i];
    end
    if (!hold) d_req[i] = 1'b0;
    chk($sformatf("u%0d data_completes", i), 32'(got), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int ren0, wen0;
    n_ren = '{0, 0};
    n_wen = '{0, 0};
    last_saddr = '{16'h0, 16'h0};
    if_req = '0; d_req = '0; d_we = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d reset_flags", i),
          32'({r_en[i], w_en[i], if_ready[i], d_ready[i], d_err[i], busy[i]}), 32'd0);
      chk($sformatf("u%0d reset_addr_wdata", i), {addr[i], w_data[i]}, 32'd0);
      chk($sformatf("u%0d reset_rdata", i), {if_rdata[i], d_rdata[i]}, 32'd0);
      chk($sformatf("u%0d reset_state", i), 32'(state_dbg[i]), 32'd0);
    end
    reset = 1'b0;

    // Fetch only: word at 0, ready in the cycle after edge k+2.
    @(negedge clk); k = cyc + 1; ren0 = n_ren[0];
    fetch_tx(0, 16'h0000, 16'hABCD, k + 2, 1'b0);
    chk("t1 r_en_pulses", 32'(n_ren[0] - ren0), 32'd1);
    chk("t1 strobe_addr", 32'(last_saddr[0]), 32'h0000);
    chk("t1 if_rdata_held", 32'(if_rdata[0]), 32'hABCD);

    // Data write above the protected region, then read it back.
    @(negedge clk); k = cyc + 1; wen0 = n_wen[0];
    data_tx(0, 1'b1, 16'hC000, 16'h0102, 16'h0000, 1'b0, k + 2, 1'b0);
    chk("t2 w_en_pulses", 32'(n_wen[0] - wen0), 32'd1);
    chk("t2 strobe_addr", 32'(last_saddr[0]), 32'hC000);
    chk("t2 mem_written", 32'(mem[0][16'hC000]), 32'h0102);
    @(negedge clk); k = cyc + 1;
    data_tx(0, 1'b0, 16'hC000, 16'h0000, 16'h0102, 1'b0, k + 2, 1'b0);

    // Protected writes: blocked below PROT_TOP, allowed at PROT_TOP.
    @(negedge clk); k = cyc + 1; wen0 = n_wen[0]; ren0 = n_ren[0];
    data_tx(0, 1'b1, 16'h0800, 16'h1111, 16'h0000, 1'b1, k + 1, 1'b0);
    @(negedge clk); k = cyc + 1;
    data_tx(0, 1'b1, 16'h0FFF, 16'h2222, 16'h0000, 1'b1, k + 1, 1'b0);
    chk("t5 no_strobes", 32'({n_wen[0] - wen0, n_ren[0] - ren0}), 32'd0);
    chk("t5 mem_0800_kept", 32'(mem[0][16'h0800]), 32'(16'h0800 ^ 16'h5A5A));
    chk("t5 mem_0fff_kept", 32'(mem[0][16'h0FFF]), 32'(16'h0FFF ^ 16'h5A5A));
    @(negedge clk); k = cyc + 1;
    data_tx(0, 1'b1, 16'h1000, 16'h3333, 16'h0000, 1'b0, k + 2, 1'b0);
    chk("t5 mem_1000_written", 32'(mem[0][16'h1000]), 32'h3333);

    // Round-robin: a lone fetch leaves last_grant=FETCH, so the contended run goes D,F,D,F,D.
    @(negedge clk); k = cyc + 1;
    fetch_tx(0, 16'h0010, 16'h0010 ^ 16'h5A5A, k + 2, 1'b0);
    @(negedge clk); k = cyc + 1;
    fork
      begin
        data_tx(0, 1'b0, 16'h0020, 16'h0, 16'h0020 ^ 16'h5A5A, 1'b0, k + 2, 1'b1);
        data_tx(0, 1'b0, 16'h0021, 16'h0, 16'h0021 ^ 16'h5A5A, 1'b0, k + 8, 1'b1);
        data_tx(0, 1'b0, 16'h0022, 16'h0, 16'h0022 ^ 16'h5A5A, 1'b0, k + 14, 1'b0);
      end
      begin
        fetch_tx(0, 16'h0030, 16'h0030 ^ 16'h5A5A, k + 5, 1'b1);
        fetch_tx(0, 16'h0031, 16'h0031 ^ 16'h5A5A, k + 11, 1'b0);
      end
    join

    // Fixed priority, RD_LAT=3: data starves fetch until d_req drops.
    @(negedge clk); k = cyc + 1;
    fork
      begin
        data_tx(1, 1'b0, 16'h0040, 16'h0, 16'h0040 ^ 16'h5A5A, 1'b0, k + 4, 1'b1);
        data_tx(1, 1'b0, 16'h0041, 16'h0, 16'h0041 ^ 16'h5A5A, 1'b0, k + 9, 1'b1);
        data_tx(1, 1'b0, 16'h0042, 16'h0, 16'h0042 ^ 16'h5A5A, 1'b0, k + 14, 1'b0);
      end
      fetch_tx(1, 16'h0050, 16'h0050 ^ 16'h5A5A, k + 19, 1'b0);
    join
    // No protection when PROT_TOP=0: address 0 is writable.
    @(negedge clk); k = cyc + 1;
    data_tx(1, 1'b1, 16'h0000, 16'h7777, 16'h0000, 1'b0, k + 2, 1'b0);
    chk("t4 mem_0_written", 32'(mem[1][16'h0000]), 32'h7777);

    // Reset during WAIT: transaction dropped, no ready, next request completes.
    @(negedge clk); if_req[1] = 1'b1; if_addr[1] = 16'h0060;
    @(negedge clk);
    @(negedge clk);
    chk("t6 state_wait", 32'(state_dbg[1]), 32'd2);
    chk("t6 busy_in_wait", 32'(busy[1]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    if_req[1] = 1'b0;
    chk("t6 state_idle", 32'(state_dbg[1]), 32'd0);
    chk("t6 outputs_after_reset",
        32'({r_en[1], w_en[1], if_ready[1], d_ready[1], busy[1]}), 32'd0);
    chk("t6 if_rdata_cleared", 32'(if_rdata[1]), 32'h0000);
    repeat (8) @(negedge clk);
    @(negedge clk); k = cyc + 1;
    fetch_tx(1, 16'h0060, 16'h0060 ^ 16'h5A5A, k + 4, 1'b0);

    repeat (3) @(negedge clk);
    for (int q = 0; q < 4; q++) chk($sformatf("queue%0d_drained", q), 32'(exp_q[q].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
